// File: rtl/controle_polinomio_pkg.sv
// rtl/controle_polinomio_pkg.sv - state, mux select and ULA op codes for the polynomial controller
package controle_polinomio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_MUL_A  = 3'd2,
    ST_ADD_B  = 3'd3,
    ST_MUL_X  = 3'd4,
    ST_ADD_C  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [1:0] SEL_A     = 2'd0;
  localparam logic [1:0] SEL_B     = 2'd1;
  localparam logic [1:0] SEL_C     = 2'd2;

  localparam logic [1:0] M1_OUTM0  = 2'd0;
  localparam logic [1:0] M1_X      = 2'd1;
  localparam logic [1:0] M1_S      = 2'd2;
  localparam logic [1:0] M1_H      = 2'd3;

  localparam logic [1:0] M2_X      = 2'd0;
  localparam logic [1:0] M2_OUTM0  = 2'd1;
  localparam logic [1:0] M2_S      = 2'd2;
  localparam logic [1:0] M2_H      = 2'd3;

  localparam logic       OP_ADD    = 1'b0;
  localparam logic       OP_MUL    = 1'b1;

endpackage

// File: rtl/controle_polinomio_contador_espera.sv
// rtl/controle_polinomio_contador_espera.sv - multiply wait counter with terminal-count flag
module contador_espera #(
  parameter int MULT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int              W    = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [W-1:0]    LAST = W'(MULT_CYCLES - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == LAST);

endmodule

// File: rtl/controle_polinomio.sv
// rtl/controle_polinomio.sv - Moore FSM sequencing Horner evaluation of A*X^2 + B*X + C
module controle_polinomio
  import controle_polinomio_pkg::*;
#(
  parameter int MULT_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       ls,
  output logic       lx,
  output logic       lh,
  output logic       h,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
);

  state_t r_state;
  state_t w_next;
  logic   w_in_mul;
  logic   w_tc;

  assign w_in_mul = (r_state == ST_MUL_A) || (r_state == ST_MUL_X);

  // Clearing on the terminal cycle leaves the count at zero for the next multiply step.
  contador_espera #(.MULT_CYCLES(MULT_CYCLES)) u_contador (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (!w_in_mul || w_tc),
    .i_enable (w_in_mul),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    m0     = SEL_A;
    m1     = M1_OUTM0;
    m2     = M2_X;
    ls     = 1'b0;
    lx     = 1'b0;
    lh     = 1'b0;
    h      = OP_ADD;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = start ? ST_LOAD_X : ST_IDLE;
      end
      ST_LOAD_X: begin
        lx     = 1'b1;
        busy   = 1'b1;
        w_next = ST_MUL_A;
      end
      ST_MUL_A: begin
        m0     = SEL_A;
        m1     = M1_OUTM0;
        m2     = M2_X;
        h      = OP_MUL;
        ls     = w_tc;
        busy   = 1'b1;
        w_next = w_tc ? ST_ADD_B : ST_MUL_A;
      end
      ST_ADD_B: begin
        m0     = SEL_B;
        m1     = M1_OUTM0;
        m2     = M2_S;
        ls     = 1'b1;
        busy   = 1'b1;
        w_next = ST_MUL_X;
      end
      ST_MUL_X: begin
        m1     = M1_X;
        m2     = M2_S;
        h      = OP_MUL;
        ls     = w_tc;
        busy   = 1'b1;
        w_next = w_tc ? ST_ADD_C : ST_MUL_X;
      end
      ST_ADD_C: begin
        m0     = SEL_C;
        m1     = M1_OUTM0;
        m2     = M2_S;
        ls     = 1'b1;
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = start ? ST_DONE : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign step = r_state;

endmodule

// File: tb/tb_controle_polinomio.sv
// tb/tb_controle_polinomio.sv - self-checking bench for controle_polinomio with a behavioural datapath
module tb_controle_polinomio;

  logic        clock;
  logic        reset_n;
  logic        start [2];
  logic [1:0]  m0 [2];
  logic [1:0]  m1 [2];
  logic [1:0]  m2 [2];
  logic        ls [2];
  logic        lx [2];
  logic        lh [2];
  logic        h [2];
  logic        busy [2];
  logic        done [2];
  logic [2:0]  step [2];

  logic [15:0] in_a, in_b, in_c, in_x;
  logic [15:0] s_reg [2];
  logic [15:0] x_reg [2];
  logic [15:0] s_hist [2][$];

  int vectors;
  int miscompares;

  typedef struct {
    int st;
    int pos;
  } tl_t;

  controle_polinomio #(.MULT_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start[0]),
    .m0(m0[0]), .m1(m1[0]), .m2(m2[0]), .ls(ls[0]), .lx(lx[0]), .lh(lh[0]),
    .h(h[0]), .busy(busy[0]), .done(done[0]), .step(step[0])
  );

  controle_polinomio #(.MULT_CYCLES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start[1]),
    .m0(m0[1]), .m1(m1[1]), .m2(m2[1]), .ls(ls[1]), .lx(lx[1]), .lh(lh[1]),
    .h(h[1]), .busy(busy[1]), .done(done[1]), .step(step[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] ula(input logic [1:0] s0, input logic [1:0] s1,
                                      input logic [1:0] s2, input logic op,
                                      input logic [15:0] xv, input logic [15:0] sv);
    logic [15:0] outm0, a1, a2;
    outm0 = (s0 == 2'd1) ? in_b : (s0 == 2'd2) ? in_c : in_a;
    case (s1)
      2'd0: a1 = outm0;
      2'd1: a1 = xv;
      2'd2: a1 = sv;
      default: a1 = 16'd0;
    endcase
    case (s2)
      2'd0: a2 = xv;
      2'd1: a2 = outm0;
      2'd2: a2 = sv;
      default: a2 = 16'd0;
    endcase
    return op ? 16'(a1 * a2) : 16'(a1 + a2);
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (ls[d]) begin
        s_reg[d] <= ula(m0[d], m1[d], m2[d], h[d], x_reg[d], s_reg[d]);
        s_hist[d].push_back(ula(m0[d], m1[d], m2[d], h[d], x_reg[d], s_reg[d]));
      end
      if (lx[d]) x_reg[d] <= in_x;
    end
  end

  function automatic logic [11:0] pack_obs(input int d);
    return {m0[d], m1[d], m2[d], ls[d], lx[d], lh[d], h[d], busy[d], done[d]};
  endfunction

  // Expected control word {m0,m1,m2,ls,lx,lh,h,busy,done} for a step and its cycle index.
  function automatic logic [11:0] exp_ctrl(input int st, input int pos, input int mc);
    logic last;
    last = (pos == mc - 1);
    case (st)
      1: return {2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      2: return {2'd0, 2'd0, 2'd0, last, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      3: return {2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      4: return {2'd0, 2'd1, 2'd2, last, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      5: return {2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      6: return {2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default: return 12'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_poly(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] x,
                          input bit toggle, input int hold);
    tl_t         tl [$];
    int          mc;
    logic [15:0] p1, p2, p3, p4;
    mc = (d == 1) ? 3 : 1;
    in_a = a; in_b = b; in_c = c; in_x = x;
    s_hist[d].delete();
    chk("idle_step", 32'(step[d]), 32'd0);
    tl.push_back('{1, 0});
    for (int i = 0; i < mc; i++) tl.push_back('{2, i});
    tl.push_back('{3, 0});
    for (int i = 0; i < mc; i++) tl.push_back('{4, i});
    tl.push_back('{5, 0});
    tl.push_back('{6, 0});
    start[d] = 1'b1;
    foreach (tl[i]) begin
      @(negedge clock);
      chk($sformatf("step_d%0d_i%0d", d, i), 32'(step[d]), 32'(tl[i].st));
      chk($sformatf("ctrl_d%0d_i%0d", d, i), 32'(pack_obs(d)),
          32'(exp_ctrl(tl[i].st, tl[i].pos, mc)));
      if (toggle && tl[i].st >= 2 && tl[i].st <= 4) start[d] = 1'($urandom_range(0, 1));
      else start[d] = 1'b1;
    end
    p1 = 16'(a * x);
    p2 = 16'(p1 + b);
    p3 = 16'(p2 * x);
    p4 = 16'(p3 + c);
    chk("y_ref", 32'(s_reg[d]), 32'(16'(a * x * x + b * x + c)));
    chk("s_loads", s_hist[d].size(), 4);
    if (s_hist[d].size() == 4) begin
      chk("s_seq0", 32'(s_hist[d][0]), 32'(p1));
      chk("s_seq1", 32'(s_hist[d][1]), 32'(p2));
      chk("s_seq2", 32'(s_hist[d][2]), 32'(p3));
      chk("s_seq3", 32'(s_hist[d][3]), 32'(p4));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_step", 32'(step[d]), 32'd6);
      chk("hold_done", 32'(done[d]), 32'd1);
    end
    start[d] = 1'b0;
    @(negedge clock);
    chk("back_idle", 32'(step[d]), 32'd0);
    chk("idle_ctrl", 32'(pack_obs(d)), 32'd0);
  endtask

  initial begin
    int guard;
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_x = '0;
    s_reg[0] = '0; s_reg[1] = '0; x_reg[0] = '0; x_reg[1] = '0;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_step", 32'(step[d]), 32'd0);
      chk("rst_ctrl", 32'(pack_obs(d)), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);

    run_poly(0, 16'd2, 16'd3, 16'd4, 16'd5, 1'b0, 0);
    chk("y_69", 32'(s_reg[0]), 32'd69);
    run_poly(0, 16'hFFFF, 16'd0, 16'd0, 16'hFF80, 1'b0, 0);
    chk("y_neg", 32'(s_reg[0]), 32'h0000C000);
    run_poly(0, 16'd1, 16'd0, 16'd0, 16'hFF80, 1'b0, 0);
    chk("y_pos", 32'(s_reg[0]), 32'h00004000);
    run_poly(1, 16'd1, 16'd1, 16'd1, 16'd2, 1'b0, 0);
    chk("y_7", 32'(s_reg[1]), 32'd7);
    run_poly(0, 16'(  $urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 3);
    run_poly(1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 2);
    run_poly(0, 16'd2, 16'd3, 16'd4, 16'd5, 1'b1, 0);
    chk("y_toggle", 32'(s_reg[0]), 32'd69);
    for (int r = 0; r < 6; r++)
      run_poly(r % 2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

    in_a = 16'd2; in_b = 16'd3; in_c = 16'd4; in_x = 16'd5;
    start[1] = 1'b1;
    guard = 0;
    while (step[1] !== 3'd4 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    chk("reach_mul_x", 32'(step[1]), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("async_rst_step", 32'(step[1]), 32'd0);
    chk("async_rst_ctrl", 32'(pack_obs(1)), 32'd0);
    start[1] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", 32'(step[1]), 32'd0);
    run_poly(1, 16'd1, 16'd1, 16'd1, 16'd2, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
